// File: rtl/trace_buffer_pkg.sv
// Shared debugger definitions: trace-buffer states and the packed vector type
// exchanged with the data packer.
package trace_buffer_pkg;

    localparam int TB_N          = 8;
    localparam int TB_DATA_WIDTH = 32;

    // One packed beat: TB_N lanes of TB_DATA_WIDTH bits, lane 0 in the low bits.
    typedef logic [TB_N-1:0][TB_DATA_WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACE  = 2'd1,
        FROZEN = 2'd2,
        DRAIN  = 2'd3
    } tb_state_t;

endpackage

// File: rtl/trace_buffer_mem.sv
// Simple dual-port trace RAM: one write port and one registered read port.
// Storage has no reset; the controller never reads a slot before writing it.
module trace_mem
    import trace_buffer_pkg::*;
#(
    parameter int WIDTH = TB_N * TB_DATA_WIDTH,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and 1-cycle-latency read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_buffer.sv
// Circular trace store: keeps the newest DEPTH packed vectors while tracing,
// freezes them, and drains oldest-first over a ready/valid stream.
//
//   state  | meaning
//   IDLE   | empty, waiting for tracing
//   TRACE  | capturing valid vectors, overwriting the oldest when full
//   FROZEN | contents held; may resume tracing or start a drain
//   DRAIN  | streaming count beats out, then clears back to IDLE
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int N          = TB_N,
    parameter int DATA_WIDTH = TB_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tracing,
    input  logic                             valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    input  logic                             drain_start,
    input  logic                             ready_out,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic                             valid_out,
    output logic                             last_out,
    output logic [$clog2(DEPTH+1)-1:0]       count_out,
    output logic                             wrapped_out,
    output logic                             draining_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    tb_state_t                    state;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic [CW-1:0]                rd_cnt;
    logic                         wrapped;

    logic [N-1:0][DATA_WIDTH-1:0] rd_data;
    logic                         rd_pend;
    logic                         rd_pend_last;
    logic [N-1:0][DATA_WIDTH-1:0] skid_data;
    logic                         skid_valid;
    logic                         skid_last;
    logic [N-1:0][DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_last;

    logic                         wr_en;
    logic                         xfer;
    logic                         done;
    logic [1:0]                   occ;
    logic [1:0]                   occ_after;
    logic                         rd_issue;
    logic                         issue_last;

    assign wr_en      = (state == TRACE) && tracing && valid_in;
    assign xfer       = out_valid && ready_out;
    assign done       = xfer && out_last;
    // Beats held in the output/skid registers plus the read in flight; a new
    // read is issued only if it will still have a register to land in.
    assign occ        = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend);
    assign occ_after  = occ - 2'(xfer);
    assign rd_issue   = (state == DRAIN) && (rd_cnt < count) && (occ_after < 2'd2);
    assign issue_last = (rd_cnt == count - CW'(1));

    trace_mem #(
        .WIDTH (N * DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (vector_in),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Control FSM with write pointer, fill count, wrap flag and read issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_cnt  <= '0;
            wrapped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tracing) begin
                        state <= TRACE;
                    end
                end
                TRACE: begin
                    if (!tracing) begin
                        state <= FROZEN;
                    end else if (valid_in) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        if (count == CW'(DEPTH)) begin
                            wrapped <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                FROZEN: begin
                    if (tracing) begin
                        state <= TRACE;
                    end else if (drain_start && (count != '0)) begin
                        state  <= DRAIN;
                        rd_ptr <= wr_ptr - count[PW-1:0];
                        rd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (rd_issue) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                    if (done) begin
                        state   <= IDLE;
                        count   <= '0;
                        wr_ptr  <= '0;
                        wrapped <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read pipeline: RAM data lands in the output register when it is free,
    // otherwise in the skid register, so ready_out may drop on any cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            skid_valid   <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
        end else begin
            rd_pend      <= rd_issue;
            rd_pend_last <= issue_last;
            if (!out_valid || xfer) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_last  <= skid_last;
                end else if (rd_pend) begin
                    out_valid <= 1'b1;
                    out_data  <= rd_data;
                    out_last  <= rd_pend_last;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
            if (skid_valid && (!out_valid || xfer)) begin
                skid_valid <= rd_pend;
                skid_data  <= rd_data;
                skid_last  <= rd_pend_last;
            end else if (!skid_valid && rd_pend && out_valid && !xfer) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= rd_pend_last;
            end
        end
    end

    assign vector_out   = out_data;
    assign valid_out    = out_valid;
    assign last_out     = out_last;
    assign count_out    = count;
    assign wrapped_out  = wrapped;
    assign draining_out = (state == DRAIN);

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Circular trace store that sits directly downstream of the data packer. While tracing, it captures every valid packed N-wide vector and always keeps the most recent DEPTH vectors. When tracing stops, the contents are frozen. On request, it drains them oldest-first over a ready/valid stream to the host readout logic.

## Interface
- N, 8, vector lanes per beat (matches the packer's N)
- DATA_WIDTH, 32, bits per lane
- DEPTH, 16, stored vectors; power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tracing  in  1  capture enable
- valid_in  in  1  vector_in valid (packer valid_out)
- vector_in  in  [DATA_WIDTH-1:0] x N  packed vector
- drain_start  in  1  single-cycle pulse, begin readout
- ready_out  in  1  consumer accepts current beat
- vector_out  out  [DATA_WIDTH-1:0] x N  drained vector
- valid_out  out  1  vector_out valid
- last_out  out  1  qualifies the final beat of a drain
- count_out  out  $clog2(DEPTH+1)  vectors currently held
- wrapped_out  out  1  at least one vector was overwritten since last clear
- draining_out  out  1  high in DRAIN state

## Operation
- Reset value of every output is 0. State resets to IDLE, pointers and count reset to 0, wrapped resets to 0. Memory contents are don't-care.
- States: IDLE (empty), TRACE, FROZEN, DRAIN.
- IDLE: tracing=1 → TRACE.
- TRACE:
  - Each cycle with valid_in=1 and tracing=1: write vector_in at wr_ptr, then wr_ptr+1 mod DEPTH.
  - count increments up to and saturating at DEPTH.
  - A write while count==DEPTH overwrites the oldest vector and sets wrapped.
  - tracing=0 → FROZEN. A valid_in in that same cycle is not written.
- FROZEN:
  - tracing=1 → TRACE. Appends continue; count and wrapped are kept.
  - drain_start=1 with count>0 → DRAIN, with rd_ptr = (wr_ptr − count) mod DEPTH.
  - drain_start with count==0 is ignored.
  - If tracing and drain_start are high together, tracing wins.
- DRAIN:
  - Beats are issued from rd_ptr upward, exactly count of them.
  - A beat transfers on valid_out & ready_out.
  - last_out=1 only on beat number count.
  - After the last transfer: count, wr_ptr and wrapped clear, state → IDLE.
  - tracing, valid_in and drain_start are ignored in DRAIN; no writes occur.
- drain_start outside FROZEN is ignored.
- Arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is one bit wider so it can represent DEPTH.
- Asserting reset mid-drain abandons the drain immediately; valid_out drops asynchronously.

## Timing
- Write latency: count_out and wrapped_out reflect a write on the cycle after the capturing edge.
- Drain:
  - First valid_out is asserted 2 cycles after the drain_start edge (1-cycle synchronous RAM read plus output register).
  - Sustained throughput is 1 beat/cycle while ready_out=1.
- Handshake:
  - Once valid_out=1, vector_out and last_out hold stable until transfer.
  - valid_out never drops without a transfer (except reset).
  - The read path uses a one-entry skid register so ready_out can deassert on any cycle without loss or duplication.
- valid_out is 0 on the cycle after the last transfer.
- draining_out is high from the cycle after drain_start until the cycle after the last transfer.
- count_out is constant during DRAIN and goes to 0 on the cycle after the last transfer.

## Structure
- Shared debugger package:
  - state enum tb_state_t {IDLE, TRACE, FROZEN, DRAIN}.
  - Vector type for N x DATA_WIDTH, shared with the packer.
- Sub-module trace_mem:
  - Simple dual-port RAM, DEPTH x (N·DATA_WIDTH).
  - One write port and one synchronous read port, 1-cycle read latency, no reset.
- FSM, pointers, count and skid/output register live in trace_buffer.

## Test plan
All scenarios use N=8, DEPTH=8.
- Partial fill: tracing=1, 5 valid vectors with lane0 = 1..5, then tracing=0, drain_start, ready_out=1 → 5 beats lane0 = 1,2,3,4,5; last_out on beat 5; first valid_out 2 cycles after drain_start; count_out 5→0; wrapped_out=0.
- Wrap: 11 vectors lane0 = 1..11, freeze, drain → 8 beats lane0 = 4..11; wrapped_out=1 before drain; count_out=8.
- Backpressure: in the wrap scenario, toggle ready_out 1,0,0,1,0,1… → same 8 values, no duplicates or drops, vector_out stable while valid_out=1 and ready_out=0.
- Resume and ignore:
  - Freeze after 3 vectors, re-assert tracing, 2 more, freeze, drain → lane0 = 1..5.
  - valid_in pulses during DRAIN are not stored; next capture starts at count 0.
- Empty/illegal drain: drain_start in IDLE and in FROZEN with count=0 → no valid_out, state unchanged. drain_start and tracing together in FROZEN → TRACE.
- Reset mid-drain: rst_n low after beat 3 of 8 → all outputs 0 immediately, state IDLE, count_out=0. Subsequent capture of 2 vectors drains exactly 2 beats.
